regfile_shift_unit: RTL and testbench
=====================================

Name: regfile_shift_unit

Overview:
- Integer register file (32 x 64-bit, two read ports, one write port) for the multicycle RV64 datapath. It also contains the immediate-shift unit.
- The shift unit extracts the 6-bit shift amount from the current instruction and shifts the rs1 read data.
- Sits between the instruction register and the RegA/RegB/write-back muxes.
- The shift result feeds the write-back mux.

Parameters:
- DATA_W, 64, register and datapath width; only 64 is supported.
- NREGS, 32, number of architectural registers; addresses are log2(NREGS)=5 bits.

Ports:
- Clk  in  1  system clock, rising-edge active
- Reset  in  1  synchronous, active-high reset
- RegWrite  in  1  write enable for the write port
- ReadReg1  in  5  rs1 address (instr[19:15])
- ReadReg2  in  5  rs2 address (instr[24:20])
- WriteReg  in  5  rd address (instr[11:7])
- WriteData  in  64  write-back data
- Instr  in  32  current instruction word from the instruction register
- ShiftControl  in  2  shift operation select
- ReadData1  out  64  rs1 data
- ReadData2  out  64  rs2 data
- ShiftN  out  6  extracted shift amount
- ShiftOut  out  64  shifted rs1 data

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Reset).
- Reset: on a rising Clk edge with Reset=1, all 32 registers become 0.
  - Reset has priority over a simultaneous write; that write is discarded.
- Write: on a rising Clk edge with Reset=0 and RegWrite=1, reg[WriteReg] <= WriteData.
  - Writes to address 0 are ignored; reg[0] always reads 64'h0.
  - RegWrite=0 leaves all registers unchanged.
- Reads: ReadData1 = reg[ReadReg1] and ReadData2 = reg[ReadReg2], purely combinational with zero latency.
  - Address 0 always returns 0.
  - Both ports may address the same register.
- Read-during-write to the same address, default build: the read returns the old value. The new value is visible after the edge.
- ShiftN = Instr[25:20], combinational. This is the RV64 shamt of slli/srli/srai.
  - For srai, Instr[30] (funct6 bit) is outside this field and does not affect ShiftN.
- ShiftOut is combinational from ReadData1, ShiftN and ShiftControl:
  - 2'b00: logical left, ReadData1 << ShiftN; zeros fill from the right.
  - 2'b01: logical right, ReadData1 >> ShiftN; zeros fill from the left.
  - 2'b10: arithmetic right; ReadData1[63] is replicated into the vacated bits.
  - 2'b11: pass-through, ShiftOut = ReadData1.
- Shift boundaries:
  - ShiftN=0 returns ReadData1 unchanged for all ops.
  - ShiftN=63 is the maximum.
  - There is no wrap-around or rotation; bits shifted out are lost.
- There are no internal pipeline registers other than the register array itself.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined, read ports forward in the same cycle: if RegWrite=1, Reset=0, WriteReg!=0 and ReadRegN==WriteReg, then ReadDataN = WriteData.
  - ShiftOut uses the forwarded ReadData1.
- When undefined, read ports show array contents only (old value on read-during-write).

Decomposition:
- Shared package regfile_pkg:
  - constants XLEN=64, NREGS=32, REG_AW=5, SHAMT_W=6;
  - enum shift_op_t {SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_PASS=2'b11};
  - constants SHAMT_LSB=20 and SHAMT_MSB=25.
- One natural sub-module: shift_unit_64.
  - Combinational; inputs data, shamt and op; output the result.
  - Top level instantiates it and holds the register array, the write logic and the shamt extraction.

Test Plan:
- Reset: write x5=64'hDEAD_BEEF_0000_0001, then assert Reset for one edge -> ReadData1 for ReadReg1=5 reads 0, and all 32 registers read 0.
- x0 protection: RegWrite=1, WriteReg=0, WriteData=64'hFFFF_FFFF_FFFF_FFFF -> ReadData1 and ReadData2 with address 0 read 0.
- Dual read / write: write x1=64'h1234 then x2=64'h5678 -> ReadReg1=1, ReadReg2=2 give 64'h1234 and 64'h5678.
  - With RegWrite=0 and WriteData changing, both values are unchanged.
- Read-during-write to x3 (old value 64'hA):
  - default build: new value 64'hB -> ReadData1 shows 64'hA before the edge and 64'hB after;
  - with REGFILE_BYPASS_EN: 64'hB immediately.
- Shifts with x4=64'h8000_0000_0000_00F0:
  - Instr with [25:20]=4 -> ShiftN=4;
  - op 00 -> 64'h0000_0000_0000_0F00;
  - op 01 -> 64'h0800_0000_0000_000F;
  - op 10 -> 64'hF800_0000_0000_000F;
  - op 11 -> 64'h8000_0000_0000_00F0.
- Shift boundaries, same x4:
  - ShiftN=0 -> unchanged for all ops;
  - ShiftN=63: op 00 -> 0, op 01 -> 64'h1, op 10 -> 64'hFFFF_FFFF_FFFF_FFFF;
  - Instr=32'h4000_0000 (bit30 only) -> ShiftN=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, shamt field position and shift-op encoding for the RV64 register file and shift unit
package regfile_pkg;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int REG_AW = 5;
  localparam int SHAMT_W = 6;
  localparam int SHAMT_LSB = 20;
  localparam int SHAMT_MSB = 25;
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_PASS = 2'b11
  } shift_op_t;
endpackage

// File: rtl/shift_unit_64.sv
// shift_unit_64: combinational 64-bit sll/srl/sra/pass; ports data, shamt, op in, result out
module shift_unit_64 import regfile_pkg::*; (
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_op_t          op,
  output logic [XLEN-1:0]    result
);
  logic [XLEN-1:0] sra;
  assign sra = $signed(data) >>> shamt;
  always_comb result = op == SH_SLL ? data << shamt : op == SH_SRL ? data >> shamt : op == SH_SRA ? sra : data;
endmodule

// File: rtl/regfile_shift_unit.sv
// regfile_shift_unit: 32x64 RV64 register file (2R/1W, x0 hardwired 0, sync active-high Reset) plus immediate shifter; ports Clk, Reset, RegWrite, ReadReg1/2, WriteReg, WriteData, Instr, ShiftControl in; ReadData1/2, ShiftN, ShiftOut out; define REGFILE_BYPASS_EN to forward write data to same-cycle reads
module regfile_shift_unit import regfile_pkg::*; #(
  parameter int DATA_W = XLEN,
  parameter int NREGS = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [REG_AW-1:0] ReadReg1,
  input  logic [REG_AW-1:0] ReadReg2,
  input  logic [REG_AW-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [31:0]       Instr,
  input  logic [1:0]        ShiftControl,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [SHAMT_W-1:0] ShiftN,
  output logic [DATA_W-1:0] ShiftOut
);
  logic [DATA_W-1:0] regs [NREGS];
  logic unusedInstr;
  always_ff @(posedge Clk)
    if (Reset) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (RegWrite && WriteReg != '0) regs[WriteReg] <= WriteData;
`ifdef REGFILE_BYPASS_EN
  logic fwdOk;
  assign fwdOk = RegWrite && !Reset && WriteReg != '0;
  always_comb begin
    ReadData1 = ReadReg1 == '0 ? '0 : fwdOk && ReadReg1 == WriteReg ? WriteData : regs[ReadReg1];
    ReadData2 = ReadReg2 == '0 ? '0 : fwdOk && ReadReg2 == WriteReg ? WriteData : regs[ReadReg2];
  end
`else
  always_comb begin
    ReadData1 = ReadReg1 == '0 ? '0 : regs[ReadReg1];
    ReadData2 = ReadReg2 == '0 ? '0 : regs[ReadReg2];
  end
`endif
  assign ShiftN = Instr[SHAMT_MSB:SHAMT_LSB];
  assign unusedInstr = ^{Instr[31:SHAMT_MSB+1], Instr[SHAMT_LSB-1:0]};
  shift_unit_64 u_shift (
    .data(ReadData1),
    .shamt(ShiftN),
    .op(shift_op_t'(ShiftControl)),
    .result(ShiftOut)
  );
endmodule

// File: tb/tb_regfile_shift_unit.sv
// tb_regfile_shift_unit: randomized scoreboard bench for regfile_shift_unit against an array/arithmetic reference model
module tb_regfile_shift_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b0, RegWrite = 1'b0;
  logic [4:0] ReadReg1 = '0, ReadReg2 = '0, WriteReg = '0;
  logic [63:0] WriteData = '0;
  logic [31:0] Instr = '0;
  logic [1:0] ShiftControl = '0;
  logic [63:0] ReadData1, ReadData2, ShiftOut;
  logic [5:0] ShiftN;
  typedef struct {
    string tag;
    logic [63:0] r1, r2, sh;
    logic [5:0] n;
  } exp_t;
  exp_t q[$];
  logic [63:0] model [32];
  int tests = 0, fails = 0;
  always #5 Clk = ~Clk;
  regfile_shift_unit dut (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
    .WriteData(WriteData), .Instr(Instr), .ShiftControl(ShiftControl),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ShiftN(ShiftN), .ShiftOut(ShiftOut)
  );
  function automatic logic [63:0] refShift(logic [63:0] x, int n, int op);
    logic [63:0] ones = {64{1'b1}};
    case (op)
      0: return x << n;
      1: return x >> n;
      2: return (x >> n) | (x[63] ? ~(ones >> n) : 64'h0);
      default: return x;
    endcase
  endfunction
  function automatic logic [63:0] refRead(logic [4:0] a, bit rst, bit we, logic [4:0] wr, logic [63:0] wd);
    if (a == 0) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && wr == a) return wd;
`endif
    return model[a];
  endfunction
  task automatic step(string tag, bit rst, bit we, logic [4:0] wr, logic [63:0] wd,
                      logic [4:0] a, logic [4:0] b, logic [31:0] ins, logic [1:0] ctl);
    exp_t e;
    Reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
    ReadReg1 = a; ReadReg2 = b; Instr = ins; ShiftControl = ctl;
    e.tag = tag;
    e.r1 = refRead(a, rst, we, wr, wd);
    e.r2 = refRead(b, rst, we, wr, wd);
    e.n = ins[25:20];
    e.sh = refShift(e.r1, int'(e.n), int'(ctl));
    q.push_back(e);
    @(posedge Clk);
    if (rst) for (int i = 0; i < 32; i++) model[i] = 64'h0;
    else if (we && wr != 0) model[wr] = wd;
    #1;
  endtask
  task automatic chk(string tag, string field, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %h expected %h", tag, field, act, exp);
    end
  endtask
  always @(negedge Clk)
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, "ReadData1", ReadData1, e.r1);
      chk(e.tag, "ReadData2", ReadData2, e.r2);
      chk(e.tag, "ShiftN", {58'h0, ShiftN}, {58'h0, e.n});
      chk(e.tag, "ShiftOut", ShiftOut, e.sh);
    end
  function automatic logic [31:0] sh(int n);
    return 32'(n) << 20;
  endfunction
  initial begin
    @(posedge Clk); #1;
    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0);
    step("wx5", 0, 1, 5, 64'hDEAD_BEEF_0000_0001, 5, 0, 0, 3);
    step("rstprio", 1, 1, 7, 64'h123, 5, 7, 0, 3);
    step("rd5", 0, 0, 0, 0, 5, 7, 0, 3);
    for (int i = 0; i < 32; i++) step("allzero", 0, 0, 0, 0, 5'(i), 5'(31 - i), $urandom, 2'($urandom_range(3)));
    step("wx0", 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 3);
    step("rdx0", 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 3);
    step("wx1", 0, 1, 1, 64'h1234, 1, 2, 0, 3);
    step("wx2", 0, 1, 2, 64'h5678, 1, 2, 0, 3);
    step("dual", 0, 0, 2, 64'h9999, 1, 2, 0, 3);
    step("nowe", 0, 0, 1, 64'hAAAA, 1, 2, 0, 3);
    step("wx3", 0, 1, 3, 64'hA, 3, 3, 0, 3);
    step("rdw", 0, 1, 3, 64'hB, 3, 3, 0, 3);
    step("rdw_after", 0, 0, 0, 0, 3, 3, 0, 3);
    step("wx4", 0, 1, 4, 64'h8000_0000_0000_00F0, 0, 0, 0, 3);
    for (int op = 0; op < 4; op++) step("sh4", 0, 0, 0, 0, 4, 0, sh(4), 2'(op));
    for (int op = 0; op < 4; op++) step("sh0", 0, 0, 0, 0, 4, 0, sh(0), 2'(op));
    for (int op = 0; op < 4; op++) step("sh63", 0, 0, 0, 0, 4, 0, sh(63), 2'(op));
    step("bit30", 0, 0, 0, 0, 4, 0, 32'h4000_0000, 2);
    step("fn", 0, 0, 0, 0, 4, 0, 32'hFFFF_FFFF, 2);
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(49) == 0, 1'($urandom), 5'($urandom), {$urandom, $urandom},
           5'($urandom), 5'($urandom), $urandom, 2'($urandom));
    @(negedge Clk); #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
